// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, op classes, decoded-instruction record and the pure decode function
package decode_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    // Decodes to the idle/reset output values (ILLEGAL, everything zero)
    localparam logic [31:0] IDLE_WORD = 32'hFC00_0000;

    typedef enum logic [2:0] {
        OC_ALU     = 3'd0,
        OC_LOAD    = 3'd1,
        OC_STORE   = 3'd2,
        OC_BRANCH  = 3'd3,
        OC_ILLEGAL = 3'd4
    } op_class_e;

    typedef struct packed {
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  wa;
        logic        we;
        logic [31:0] imm;
        op_class_e   op_class;
        logic [5:0]  funct;
    } decoded_t;

    function automatic decoded_t decode(input logic [31:0] instr);
        decoded_t d;
        logic [31:0] sext;
        sext = {{16{instr[15]}}, instr[15:0]};
        d.ra1 = instr[25:21];
        d.ra2 = '0;
        d.wa = instr[20:16];
        d.we = 1'b1;
        d.imm = sext;
        d.op_class = OC_ALU;
        d.funct = instr[5:0];
        case (instr[31:26])
            OP_RTYPE: begin
                d.ra2 = instr[20:16];
                d.wa = instr[15:11];
                d.imm = '0;
            end
            OP_ADDI: d.imm = sext;
            OP_ANDI, OP_ORI: d.imm = {16'h0, instr[15:0]};
            OP_LW: d.op_class = OC_LOAD;
            OP_SW, OP_BEQ: begin
                d.ra2 = instr[20:16];
                d.wa = '0;
                d.we = 1'b0;
                d.op_class = (instr[31:26] == OP_SW) ? OC_STORE : OC_BRANCH;
            end
            default: begin
                d.ra1 = '0;
                d.wa = '0;
                d.we = 1'b0;
                d.imm = '0;
                d.op_class = OC_ILLEGAL;
            end
        endcase
        d.we = d.we & (d.wa != '0);
        return d;
    endfunction
endpackage

// File: rtl/instr_decode_scoreboard.sv
// scoreboard: one pending bit per register; set on issue, cleared on writeback, set wins
module scoreboard #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rd1_addr,
    input  logic [AW-1:0] rd2_addr,
    input  logic [AW-1:0] rd3_addr,
    output logic          hit1,
    output logic          hit2,
    output logic          hit3
);
    localparam int N = 1 << AW;

    logic [N-1:0] pending_q, pending_d;

    always_comb begin
        pending_d = flush ? '0 : (pending_q & ~(N'(clr_en) << clr_addr)) | (N'(set_en) << set_addr);
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    assign hit1 = pending_q[rd1_addr];
    assign hit2 = pending_q[rd2_addr];
    assign hit3 = pending_q[rd3_addr];
endmodule

// File: rtl/instr_decode.sv
// instr_decode: single-entry decode stage with scoreboard-based RAW/WAW stall
module instr_decode
    import decode_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    input  logic          flush,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_wa,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] ra1,
    output logic [AW-1:0] ra2,
    output logic [AW-1:0] wa,
    output logic          we,
    output logic [31:0]   imm,
    output logic [2:0]    op_class,
    output logic [5:0]    funct
);
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] instr_q, instr_d;
    decoded_t    dec;
    logic        hit1, hit2, hit3, issue, accept;

    always_comb begin
        dec = decode(hold_valid_q ? instr_q : IDLE_WORD);
        out_valid = hold_valid_q & ~(hit1 | hit2 | (dec.we & hit3));
        issue = out_valid & out_ready;
        in_ready = ~hold_valid_q | issue;
        accept = in_valid & in_ready;
        hold_valid_d = flush ? 1'b0 : accept ? 1'b1 : issue ? 1'b0 : hold_valid_q;
        instr_d = accept ? in_instr : instr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= 1'b0;
            instr_q <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            instr_q <= instr_d;
        end
    end

    scoreboard #(.AW(AW)) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .set_en  (issue & we),
        .set_addr(wa),
        .clr_en  (wb_valid),
        .clr_addr(wb_wa),
        .rd1_addr(ra1),
        .rd2_addr(ra2),
        .rd3_addr(wa),
        .hit1    (hit1),
        .hit2    (hit2),
        .hit3    (hit3)
    );

    assign ra1 = AW'(dec.ra1);
    assign ra2 = AW'(dec.ra2);
    assign wa = AW'(dec.wa);
    assign we = dec.we;
    assign imm = dec.imm;
    assign op_class = dec.op_class;
    assign funct = dec.funct;
endmodule

// File: doc/instr_decode.md
# instr_decode

Single-entry decode stage directly upstream of `regfile`. It accepts 32-bit MIPS-style instructions over a valid/ready handshake and decodes them into the register-file read addresses (`ra1`, `ra2`), write address and enable (`wa`, `we`), and an extended immediate. It tracks outstanding register writes in a scoreboard and stalls on RAW/WAW hazards until writeback clears them.

## Interface
- `AW`, 5: register address width (2**AW registers; register 0 is hardwired zero)
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `in_valid` in 1: instruction offered
- `in_ready` out 1: stage can accept
- `in_instr` in 32: instruction word
- `flush` in 1: synchronous discard of held instruction and scoreboard
- `wb_valid` in 1: writeback retiring a register write
- `wb_wa` in AW: register being retired
- `out_valid` out 1: decoded instruction presented
- `out_ready` in 1: downstream accepts
- `ra1`, `ra2` out AW each: register read addresses to `regfile`
- `wa` out AW: destination register
- `we` out 1: write enable for destination
- `imm` out 32: extended immediate
- `op_class` out 3: ALU/LOAD/STORE/BRANCH/ILLEGAL (`decode_pkg::op_class_e`)
- `funct` out 6: R-type function field, passed through

## Operation
- Fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm16 [15:0].
- Decode of the held instruction:
  - opcode 0x00 (R-type): ra1=rs, ra2=rt, wa=rd, we=1, imm=0, ALU.
  - 0x08 ADDI: ra1=rs, ra2=0, wa=rt, we=1, imm sign-extended, ALU.
  - 0x0C ANDI / 0x0D ORI: same as ADDI, but imm zero-extended.
  - 0x23 LW: ra1=rs, ra2=0, wa=rt, we=1, imm sign-extended, LOAD.
  - 0x2B SW: ra1=rs, ra2=rt, wa=0, we=0, imm sign-extended, STORE.
  - 0x04 BEQ: ra1=rs, ra2=rt, wa=0, we=0, imm sign-extended, BRANCH.
  - Any other opcode: all addresses 0, we=0, imm=0, ILLEGAL. It is still issued, never dropped.
- `wa`==0 forces `we`=0 for every class.
- Scoreboard: one `pending` bit per register.
  - Set for `wa` when an instruction with `we`=1 issues (out_valid & out_ready).
  - Cleared for `wb_wa` when `wb_valid` is high.
  - Bit 0 is never set.
  - Same-cycle set and clear of the same bit: set wins.
- Hazard: pending[ra1], pending[ra2], or (we & pending[wa]). Address 0 is never hazardous.
  - Hazard is evaluated on the registered scoreboard only. A writeback clear is not bypassed, so the stall releases the cycle after the clear.
- Holding register: `hold_valid` plus the instruction word.
  - `in_ready` = !hold_valid | (out_valid & out_ready).
  - `out_valid` = hold_valid & !hazard.
- `flush` clears `hold_valid` and the entire scoreboard. It takes priority over a same-cycle accept; the offered instruction is dropped.

## Timing
- Reset values:
  - `hold_valid`=0, scoreboard all 0.
  - `out_valid`=0, `in_ready`=1.
  - `ra1`/`ra2`/`wa`=0, `we`=0, `imm`=0, `op_class`=ILLEGAL, `funct`=0.
- Latency: an instruction accepted on edge N gives `out_valid`=1 in cycle N+1 when there is no hazard.
- Throughput is 1 per cycle when downstream is always ready and there are no hazards.
- Outputs are combinational from the holding register and stay stable while out_valid=1 and out_ready=0.
- Back-to-back dependent pair: the second instruction stalls from its hold cycle until one cycle after the matching `wb_valid`.
- Reset asserted mid-stall: all state clears immediately (asynchronous); outputs return to reset values.

## Structure
- `decode_pkg` contains:
  - opcode localparams (OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ);
  - `op_class_e` enum (3-bit);
  - `decoded_t` struct (ra1, ra2, wa, we, imm, op_class, funct).
- Sub-module `scoreboard`: pending vector with set/clear/flush ports and two read-address lookups plus one write-address lookup.
- The pure combinational decode is a function in `decode_pkg`.

## Test plan
- Reset, then ADDI r3,r1,-4 (0x2023FFFC) with out_ready=1 → next cycle: out_valid=1, ra1=1, ra2=0, wa=3, we=1, imm=0xFFFFFFFC, ALU. Bit 3 set after issue.
- ADD r3 (issued), then R-type using rs=3 → out_valid=0 until wb_valid/wb_wa=3; out_valid=1 the following cycle.
- ORI r2,r0,0x8001 → imm=0x00008001. R-type with rd=0 → we=0 and no scoreboard bit set.
- out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs stable, exactly one instruction issued afterwards.
- Opcode 0x3F → op_class=ILLEGAL, we=0, issues normally.
- flush with a held hazarded instruction and pending bits → next cycle out_valid=0, scoreboard all zero, in_ready=1.
